// File: rtl/mem_if_unit.sv
// rtl/mem_if_unit.sv - shared memory port arbitrating I-cache line fills and D-cache fills/writebacks
module mem_if_unit #(
   parameter int WORD_LENGTH = 32,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           iReq,
   input  logic [WORD_LENGTH-1:0]         iAdr,
   input  logic                           dReq,
   input  logic                           dWe,
   input  logic [WORD_LENGTH-1:0]         dAdr,
   input  logic [WORD_LENGTH-1:0]         dWdata,
   output logic                           iDone,
   output logic                           dDone,
   output logic                           iFillValid,
   output logic                           dFillValid,
   output logic [$clog2(BLOCK_WORDS)-1:0] fillIdx,
   output logic [WORD_LENGTH-1:0]         fillData,
   output logic [$clog2(BLOCK_WORDS)-1:0] wordIdx,
   output logic                           memReq,
   output logic                           memWe,
   output logic [WORD_LENGTH-1:0]         memAdr,
   output logic [WORD_LENGTH-1:0]         memWdata,
   input  logic                           memAck,
   input  logic [WORD_LENGTH-1:0]         memRdata
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam logic [WORD_LENGTH-1:0] LINE_MASK = WORD_LENGTH'((1 << (IDX_W + 2)) - 1);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, I_XFER, D_XFER, DONE} state_t;

   state_t                 state;
   state_t                 nextState;
   logic [WORD_LENGTH-1:0] base;
   logic [IDX_W-1:0]       beatCnt;
   logic                   weLat;
   logic                   ownerD;
   logic                   inXfer;
   logic                   beatAck;
   logic                   lastBeat;

   assign inXfer   = (state == I_XFER) || (state == D_XFER);
   assign beatAck  = inXfer && memAck;
   assign lastBeat = beatAck && (beatCnt == LAST_BEAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // I-cache always wins arbitration in IDLE; a running transfer is never preempted
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (iReq) begin
               nextState = I_XFER;
            end else if (dReq) begin
               nextState = D_XFER;
            end
         end
         I_XFER, D_XFER: begin
            if (lastBeat) begin
               nextState = DONE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base       <= '0;
         beatCnt    <= '0;
         weLat      <= 1'b0;
         ownerD     <= 1'b0;
         iFillValid <= 1'b0;
         dFillValid <= 1'b0;
         fillIdx    <= '0;
         fillData   <= '0;
      end else begin
         iFillValid <= 1'b0;
         dFillValid <= 1'b0;
         if (state == IDLE) begin
            beatCnt <= '0;
            if (iReq) begin
               base   <= iAdr & ~LINE_MASK;
               weLat  <= 1'b0;
               ownerD <= 1'b0;
            end else if (dReq) begin
               base   <= dAdr & ~LINE_MASK;
               weLat  <= dWe;
               ownerD <= 1'b1;
            end
         end
         if (beatAck) begin
            beatCnt <= lastBeat ? '0 : beatCnt + IDX_W'(1);
            // Writebacks return nothing to the cache, so only read beats produce a fill
            if (!weLat) begin
               iFillValid <= (state == I_XFER);
               dFillValid <= (state == D_XFER);
               fillIdx    <= beatCnt;
               fillData   <= memRdata;
            end
         end
      end
   end

   assign memReq   = inXfer;
   assign memWe    = (state == D_XFER) && weLat;
   assign memAdr   = inXfer ? base + WORD_LENGTH'({beatCnt, 2'b00}) : '0;
   assign memWdata = inXfer ? dWdata : '0;
   assign wordIdx  = beatCnt;
   assign iDone    = (state == DONE) && !ownerD;
   assign dDone    = (state == DONE) && ownerD;

endmodule

// File: tb/tb_mem_if_unit.sv
// tb/tb_mem_if_unit.sv - table-driven bench with fill scoreboard for mem_if_unit
module tb_mem_if_unit;

   localparam int WL = 32;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          iReq;
   logic [WL-1:0] iAdr;
   logic          dReq;
   logic          dWe;
   logic [WL-1:0] dAdr;
   logic [WL-1:0] dWdata;
   logic          iDone;
   logic          dDone;
   logic          iFillValid;
   logic          dFillValid;
   logic [1:0]    fillIdx;
   logic [WL-1:0] fillData;
   logic [1:0]    wordIdx;
   logic          memReq;
   logic          memWe;
   logic [WL-1:0] memAdr;
   logic [WL-1:0] memWdata;
   logic          memAck;
   logic [WL-1:0] memRdata;

   mem_if_unit #(.WORD_LENGTH(WL), .BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .iReq(iReq), .iAdr(iAdr),
      .dReq(dReq), .dWe(dWe), .dAdr(dAdr), .dWdata(dWdata),
      .iDone(iDone), .dDone(dDone),
      .iFillValid(iFillValid), .dFillValid(dFillValid),
      .fillIdx(fillIdx), .fillData(fillData), .wordIdx(wordIdx),
      .memReq(memReq), .memWe(memWe), .memAdr(memAdr), .memWdata(memWdata),
      .memAck(memAck), .memRdata(memRdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        isD;
      logic        we;
      logic [31:0] adr;
      int          ackGap;
      logic [31:0] seed;
      int          rstAfter;
      logic [31:0] expBase;
   } vec_t;

   typedef struct {
      logic        isD;
      logic [1:0]  idx;
      logic [31:0] data;
   } fill_t;

   fill_t fillQ[$];
   vec_t  vecs[6];
   int    passCnt = 0;
   int    totalCnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic checkZero(input string tag);
      chk({tag, " ctl"}, {26'd0, memReq, memWe, iDone, dDone, iFillValid, dFillValid}, 0);
      chk({tag, " memAdr"}, memAdr, 0);
      chk({tag, " memWdata"}, memWdata, 0);
      chk({tag, " fillData"}, fillData, 0);
      chk({tag, " idx"}, {28'd0, fillIdx, wordIdx}, 0);
   endtask

   task automatic sampleFill();
      fill_t f;
      if (iFillValid || dFillValid) begin
         if (fillQ.size() == 0) begin
            chk("spurious fill", {30'd0, dFillValid, iFillValid}, 0);
         end else begin
            f = fillQ.pop_front();
            chk("fill owner", {30'd0, dFillValid, iFillValid}, f.isD ? 32'd2 : 32'd1);
            chk("fill idx", {30'd0, fillIdx}, {30'd0, f.idx});
            chk("fill data", fillData, f.data);
         end
      end else if (fillQ.size() != 0) begin
         chk("missing fill", 32'(fillQ.size()), 0);
         fillQ.delete();
      end
   endtask

   task automatic doLine(input vec_t v);
      int beat = 0;
      int startCyc = -1;
      bit gotDone = 1'b0;
      if (v.isD) begin
         dReq = 1'b1; dWe = v.we; dAdr = v.adr;
      end else begin
         iReq = 1'b1; iAdr = v.adr;
      end
      for (int cyc = 0; cyc < 64 && !gotDone; cyc++) begin
         @(negedge clk);
         dWdata = 32'h100 + 32'(wordIdx);
         #1;
         sampleFill();
         if (iDone || dDone) begin
            gotDone = 1'b1;
            chk("done owner", {30'd0, dDone, iDone}, v.isD ? 32'd2 : 32'd1);
            chk("beats at done", beat, BW);
            chk("memReq in DONE", {31'd0, memReq}, 0);
            if (v.isD) dReq = 1'b0;
            else iReq = 1'b0;
            memAck = 1'b0;
         end else if (v.rstAfter != 0 && beat == v.rstAfter) begin
            rst = 1'b1; iReq = 1'b0; dReq = 1'b0; memAck = 1'b0;
            @(negedge clk);
            #1;
            checkZero("abort");
            rst = 1'b0;
            return;
         end else if (memReq) begin
            if (startCyc < 0) startCyc = cyc;
            chk("memAdr", memAdr, v.expBase + 32'(4 * beat));
            chk("memWe", {31'd0, memWe}, {31'd0, v.isD & v.we});
            chk("memWdata", memWdata, 32'h100 + 32'(beat));
            chk("wordIdx", {30'd0, wordIdx}, 32'(beat));
            memAck = (v.ackGap == 0) || (cyc % 2 == 1);
            memRdata = v.seed + 32'(beat);
            if (memAck) begin
               if (!(v.isD && v.we)) fillQ.push_back('{v.isD, 2'(beat), v.seed + 32'(beat)});
               beat++;
            end
         end else begin
            memAck = 1'b0;
         end
      end
      chk("transfer completed", {31'd0, gotDone}, 1);
      chk("start cycle", startCyc, 0);
      @(negedge clk);
      #1;
      sampleFill();
      chk("single-cycle done", {29'd0, iDone, dDone, memReq}, 0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 0, 32'hA0,    0, 32'h0000_1230};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 1, 32'h0,     0, 32'h0000_0200};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_3FFC, 0, 32'h5500,  0, 32'h0000_3FF0};
      vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFF8, 1, 32'hBEEF0, 0, 32'hFFFF_FFF0};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_1234, 0, 32'hC0,    2, 32'h0000_1230};
      vecs[5] = '{1'b0, 1'b0, 32'h0000_1234, 0, 32'hD0,    0, 32'h0000_1230};

      rst = 1'b1; iReq = 1'b1; dReq = 1'b1; dWe = 1'b0;
      iAdr = 32'h1234; dAdr = 32'h200; dWdata = 32'h100;
      memAck = 1'b1; memRdata = 32'h55;
      repeat (3) @(negedge clk);
      #1;
      checkZero("reset");
      iReq = 1'b0; dReq = 1'b0; memAck = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) doLine(vecs[i]);

      // simultaneous requests: I line first, D waits for the IDLE cycle
      dReq = 1'b1; dWe = 1'b0; dAdr = 32'h0000_0488;
      doLine('{1'b0, 1'b0, 32'h0000_2004, 0, 32'h7700, 0, 32'h0000_2000});
      doLine('{1'b1, 1'b0, 32'h0000_0488, 0, 32'h8800, 0, 32'h0000_0480});

      // stray acks while idle must not move the beat counter
      memAck = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk("idle ack wordIdx", {30'd0, wordIdx}, 0);
         chk("idle ack ctl", {29'd0, memReq, iFillValid, dFillValid}, 0);
      end
      memAck = 1'b0;
      doLine('{1'b0, 1'b0, 32'h0000_5678, 0, 32'hE0, 0, 32'h0000_5670});

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
